chu_gpo_seq: RTL and testbench
==============================

// Module: chu_gpo_seq
// PURPOSE
//  MMIO slot core that sequences a W-bit general-purpose output through a programmable pattern table.
//  Each table entry holds an output pattern and a dwell time in clock cycles.
//  Software loads the table, then starts playback once or looped; the core drives dout autonomously.
//  Sits on the slot bus beside the plain GPO core; used for LED/strobe sequences without CPU timing.
// PARAMETERS
//  W      8  output width, 1..16
//  DEPTH  8  pattern table entries, power of 2, 2..16
// PORTS
//  clk      in   1   system clock; single clock domain
//  reset    in   1   asynchronous, active-low reset
//  cs       in   1   slot select
//  read     in   1   read strobe; reads have no side effects
//  write    in   1   write strobe; write takes effect when cs && write
//  addr     in   5   register address
//  wr_data  in   32  write data
//  rd_data  out  32  combinational read data for addr
//  dout     out  W   sequenced output, registered
// BEHAVIOUR
//  Register map (unlisted addresses read 0, writes ignored):
//   0 CTRL  wr: b0 start, b1 loop, b2 stop. start and stop are pulses; loop is stored. rd: {31'b0, loop}
//   1 LEN   entries to play, 5 bits. 0 = nothing to play. Values > DEPTH clamp to DEPTH.
//   2 IDLE  W-bit value driven on dout whenever not running
//   3 STAT  rd only: b0 busy, b1 done (sticky), b[7:4] current index
//   8+i     entry i, i < DEPTH: wr_data[W-1:0] pattern, wr_data[31:16] dwell; reads back the same layout
//  Reset (asserted): state IDLE, dout=0, IDLE reg=0, LEN=0, loop=0, busy=0, done=0, index=0, table all 0
//  FSM: IDLE, RUN, DONE. DONE behaves as IDLE with done=1.
//   IDLE/DONE --start && LEN!=0--> RUN
//    - Latches min(LEN,DEPTH) and loop at the start write.
//    - Clears done and sets index=0.
//    - dout=pattern[0] on the cycle after the start write.
//   Start with LEN==0: ignored; state and done unchanged.
//   RUN: entry i holds dout for exactly max(dwell_i,1) cycles, then entry i+1 loads the next cycle.
//    - No gap cycles between entries.
//   RUN, last entry expires:
//    - loop=1: index wraps to 0 seamlessly.
//    - loop=0: go to DONE; dout=IDLE on the next cycle; busy=0; done=1.
//   stop write in RUN: next cycle state IDLE, dout=IDLE, busy=0, done unchanged.
//   start write in RUN: restart at entry 0 next cycle, dwell counter reloaded.
//   start and stop in the same write: stop wins.
//   stop write in IDLE/DONE: no effect.
//  Dwell counter: 16 bits, loaded with max(dwell,1)-1 when an entry loads; the entry advances when the counter is 0.
//  Table writes during RUN are allowed; an entry's pattern/dwell is sampled when that entry loads.
//   The currently displayed entry does not change mid-dwell.
//  LEN/loop writes during RUN affect only the next start; CTRL loop bit readback shows the stored value.
//  IDLE writes while not running update dout on the next cycle.
//  busy = (state==RUN). STAT index = entry currently on dout; 0 when not running.
//  Reset assertion mid-run forces all reset values immediately (async); playback does not resume.
// TESTING
//  Reset: hold reset low -> dout=0, STAT=0, all regs read 0; release -> dout stays 0 with no writes.
//  One-shot: entries 0..2 = {0x11,d3},{0x22,d1},{0x33,d2}; LEN=3; IDLE=0xA5; start
//   -> dout 0x11 x3, 0x22 x1, 0x33 x2, then 0xA5; STAT busy=0, done=1.
//  Loop + stop: same table, loop=1, start -> sequence repeats with no gap between 0x33 and 0x11;
//   stop mid 0x22 -> dout=0xA5 next cycle, busy=0, done=0.
//  Edges: dwell=0 on entry 1 -> held 1 cycle; LEN=20 -> plays 8 entries; LEN=0 start -> no change, busy=0.
//  Restart/collision: start in RUN -> entry 0 next cycle; start|stop in one write -> IDLE.
//   Table write to entry 2 while entry 0 shows -> new entry-2 value appears at entry 2.
//  Async reset mid-run: assert reset during entry 1 -> dout=0 without a clock edge; after release stays idle.

Source files
------------

// File: rtl/chu_gpo_seq.sv
// chu_gpo_seq: MMIO slot core that plays a software-loaded table of
// (pattern, dwell) entries onto a registered W-bit output, once or looped.
module chu_gpo_seq #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cs,
  input  logic         read,
  input  logic         write,
  input  logic [4:0]   addr,
  input  logic [31:0]  wr_data,
  output logic [31:0]  rd_data,
  output logic [W-1:0] dout
);

  localparam int         IW      = $clog2(DEPTH);
  localparam logic [4:0] DEPTH_L = 5'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A dwell of 0 behaves like 1: the counter counts down to 0 then advances.
  function automatic logic [15:0] dwell_load(input logic [15:0] dwell);
    return (dwell == 16'd0) ? 16'd0 : (dwell - 16'd1);
  endfunction

  function automatic logic [4:0] clamp_len(input logic [4:0] len);
    return (len > DEPTH_L) ? DEPTH_L : len;
  endfunction

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [4:0]      run_len_q, run_len_d;
  logic            run_loop_q, run_loop_d;
  logic            done_q, done_d;
  logic [W-1:0]    dout_q, dout_d;

  logic [4:0]      len_q;
  logic            loop_q;
  logic [W-1:0]    idle_q, idle_d;
  logic [W-1:0]    pat_q [DEPTH];
  logic [15:0]     dwl_q [DEPTH];

  logic            wr_en_s, ctrl_wr_s, start_s, stop_s, start_ok_s;
  logic            ent_hit_s, busy_s;
  logic [4:0]      ent_off_s;
  logic [IW-1:0]   ent_idx_s, idx_inc_s;
  logic            unused_s;

  assign wr_en_s    = cs & write;
  assign ctrl_wr_s  = wr_en_s & (addr == 5'd0);
  assign start_s    = ctrl_wr_s & wr_data[0];
  assign stop_s     = ctrl_wr_s & wr_data[2];
  assign start_ok_s = start_s & ~stop_s & (len_q != 5'd0);
  assign ent_off_s  = addr - 5'd8;
  assign ent_hit_s  = (addr >= 5'd8) && (ent_off_s < DEPTH_L);
  assign ent_idx_s  = ent_off_s[IW-1:0];
  assign idx_inc_s  = idx_q + IW'(1);
  assign busy_s     = (state_q == ST_RUN);
  assign dout       = dout_q;
  assign unused_s   = &{1'b0, read, wr_data};

  // Next IDLE value, so a write is visible on dout the following cycle
  always_comb begin
    if (wr_en_s && (addr == 5'd2)) begin
      idle_d = wr_data[W-1:0];
    end else begin
      idle_d = idle_q;
    end
  end

  // Software-visible configuration registers and pattern table
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q  <= 5'd0;
      loop_q <= 1'b0;
      idle_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pat_q[i] <= '0;
        dwl_q[i] <= 16'd0;
      end
    end else begin
      idle_q <= idle_d;
      if (ctrl_wr_s) begin
        loop_q <= wr_data[1];
      end
      if (wr_en_s && (addr == 5'd1)) begin
        len_q <= wr_data[4:0];
      end
      if (wr_en_s && ent_hit_s) begin
        pat_q[ent_idx_s] <= wr_data[W-1:0];
        dwl_q[ent_idx_s] <= wr_data[31:16];
      end
    end
  end

  // Playback sequencer: next state, entry index, dwell counter and output
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    run_len_d  = run_len_q;
    run_loop_d = run_loop_q;
    done_d     = done_q;
    dout_d     = dout_q;
    case (state_q)
      ST_RUN: begin
        if (stop_s) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = 16'd0;
          dout_d  = idle_d;
        end else if (start_ok_s) begin
          run_len_d  = clamp_len(len_q);
          run_loop_d = wr_data[1];
          idx_d      = '0;
          cnt_d      = dwell_load(dwl_q[0]);
          dout_d     = pat_q[0];
        end else if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else if (5'(idx_q) == (run_len_q - 5'd1)) begin
          if (run_loop_q) begin
            idx_d  = '0;
            cnt_d  = dwell_load(dwl_q[0]);
            dout_d = pat_q[0];
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            idx_d   = '0;
            cnt_d   = 16'd0;
            dout_d  = idle_d;
          end
        end else begin
          idx_d  = idx_inc_s;
          cnt_d  = dwell_load(dwl_q[idx_inc_s]);
          dout_d = pat_q[idx_inc_s];
        end
      end
      default: begin
        if (start_ok_s) begin
          state_d    = ST_RUN;
          done_d     = 1'b0;
          run_len_d  = clamp_len(len_q);
          run_loop_d = wr_data[1];
          idx_d      = '0;
          cnt_d      = dwell_load(dwl_q[0]);
          dout_d     = pat_q[0];
        end else begin
          dout_d = idle_d;
        end
      end
    endcase
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      cnt_q      <= 16'd0;
      run_len_q  <= 5'd0;
      run_loop_q <= 1'b0;
      done_q     <= 1'b0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      run_len_q  <= run_len_d;
      run_loop_q <= run_loop_d;
      done_q     <= done_d;
      dout_q     <= dout_d;
    end
  end

  // Read mux; table entries read back in their write layout
  always_comb begin
    rd_data = 32'd0;
    if (ent_hit_s) begin
      rd_data = {dwl_q[ent_idx_s], 16'(pat_q[ent_idx_s])};
    end else begin
      case (addr)
        5'd0:    rd_data = {31'd0, loop_q};
        5'd1:    rd_data = {27'd0, len_q};
        5'd2:    rd_data = 32'(idle_q);
        5'd3:    rd_data = {24'd0, 4'(idx_q), 2'd0, done_q, busy_s};
        default: rd_data = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_chu_gpo_seq.sv
// Randomized self-checking bench for chu_gpo_seq: a table-expansion model
// predicts dout and STAT for every cycle of playback.
module tb_chu_gpo_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs, read, write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic [7:0]  dout;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  m_pat [8];
  logic [15:0] m_dwl [8];
  logic [4:0]  m_len;
  logic [7:0]  m_idle;
  logic        m_loop, m_run_loop, m_done;
  logic [7:0]  seq_pat [$];
  int          seq_idx [$];

  always #5 clk = ~clk;

  chu_gpo_seq #(.W(8), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .dout(dout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_pat[i] = 8'h00;
      m_dwl[i] = 16'd0;
    end
    m_len = 5'd0; m_idle = 8'h00; m_loop = 1'b0; m_run_loop = 1'b0; m_done = 1'b0;
  endtask

  // Drive one write for exactly one rising edge
  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    @(posedge clk);
    #1;
    cs = 1'b0; write = 1'b0; wr_data = 32'd0;
  endtask

  task automatic set_entry(input int i, input logic [7:0] p, input logic [15:0] d);
    write_reg(5'(8 + i), {d, 8'h00, p});
    m_pat[i] = p;
    m_dwl[i] = d;
  endtask

  task automatic set_len(input logic [4:0] l);
    write_reg(5'd1, {27'd0, l});
    m_len = l;
  endtask

  task automatic set_idle(input logic [7:0] v);
    write_reg(5'd2, {24'd0, v});
    m_idle = v;
  endtask

  // Flatten the table into one dout value per cycle for a single pass
  task automatic build_seq();
    int n;
    int rep;
    seq_pat.delete();
    seq_idx.delete();
    n = (m_len > 5'd8) ? 8 : int'(m_len);
    for (int i = 0; i < n; i++) begin
      rep = (m_dwl[i] == 16'd0) ? 1 : int'(m_dwl[i]);
      for (int r = 0; r < rep; r++) begin
        seq_pat.push_back(m_pat[i]);
        seq_idx.push_back(i);
      end
    end
  endtask

  task automatic ctrl_write(input logic [31:0] d);
    write_reg(5'd0, d);
    m_loop = d[1];
    if (d[2]) begin
      m_run_loop = 1'b0;
    end else if (d[0] && (m_len != 5'd0)) begin
      m_run_loop = d[1];
      m_done = 1'b0;
      build_seq();
    end
    addr = 5'd0;
    #1;
    chk("ctrl_rb", rd_data, {31'd0, m_loop});
  endtask

  task automatic ctrl_start(input logic lp);
    ctrl_write({29'd0, 1'b0, lp, 1'b1});
  endtask

  function automatic logic [31:0] exp_dout(input int c);
    int l = seq_pat.size();
    if (m_run_loop) return 32'(seq_pat[c % l]);
    if (c < l) return 32'(seq_pat[c]);
    return 32'(m_idle);
  endfunction

  function automatic logic [31:0] exp_stat(input int c);
    int l = seq_pat.size();
    if (m_run_loop) return (32'(seq_idx[c % l]) << 4) | 32'd1;
    if (c < l) return (32'(seq_idx[c]) << 4) | 32'd1;
    return 32'd2;
  endfunction

  // Check cycles c0..c1-1 of the current playback, counted from the start write
  task automatic play(input string tag, input int c0, input int c1);
    for (int c = c0; c < c1; c++) begin
      addr = 5'd3;
      @(negedge clk);
      chk({tag, "_dout"}, 32'(dout), exp_dout(c));
      chk({tag, "_stat"}, rd_data, exp_stat(c));
    end
  endtask

  task automatic check_idle(input string tag, input int n);
    for (int c = 0; c < n; c++) begin
      addr = 5'd3;
      @(negedge clk);
      chk({tag, "_dout"}, 32'(dout), 32'(m_idle));
      chk({tag, "_stat"}, rd_data, {30'd0, m_done, 1'b0});
    end
  endtask

  initial begin
    logic lp;
    int   l;
    reset = 1'b0; cs = 1'b0; read = 1'b0; write = 1'b0; addr = 5'd0; wr_data = 32'd0;
    model_reset();
    #12;
    chk("rst_dout", 32'(dout), 32'd0);
    for (int a = 0; a < 16; a++) begin
      if ((a < 4) || (a >= 8)) begin
        addr = 5'(a);
        #1;
        chk("rst_reg", rd_data, 32'd0);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    check_idle("post_rst", 3);

    // One-shot playback of the reference three-entry table
    set_entry(0, 8'h11, 16'd3);
    set_entry(1, 8'h22, 16'd1);
    set_entry(2, 8'h33, 16'd2);
    set_len(5'd3);
    set_idle(8'hA5);
    check_idle("idle_wr", 1);
    ctrl_start(1'b0);
    play("oneshot", 0, seq_pat.size() + 2);
    m_done = 1'b1;
    check_idle("done", 1);

    // Looping, then stop while 0x22 is displayed (cycle 15)
    ctrl_start(1'b1);
    play("loop", 0, 16);
    chk("loop_mid22", 32'(dout), 32'h22);
    ctrl_write(32'h4);
    check_idle("stop", 2);

    // Zero dwell, LEN clamp, LEN=0 start
    set_entry(1, 8'h22, 16'd0);
    ctrl_start(1'b0);
    play("dwell0", 0, seq_pat.size() + 2);
    m_done = 1'b1;
    for (int i = 3; i < 8; i++) set_entry(i, 8'(8'h40 + i), 16'(i % 3));
    set_len(5'd20);
    ctrl_start(1'b0);
    chk("len20_entries", 32'(seq_idx[seq_idx.size() - 1]), 32'd7);
    play("len20", 0, seq_pat.size() + 2);
    m_done = 1'b1;
    set_len(5'd0);
    ctrl_start(1'b0);
    check_idle("len0", 3);

    // Restart in RUN, then start|stop collision
    set_len(5'd3);
    ctrl_start(1'b1);
    play("restart_a", 0, 5);
    ctrl_start(1'b1);
    play("restart_b", 0, 7);
    ctrl_write(32'h5);
    check_idle("collide", 2);

    // Rewrite entry 2 while entry 0 is on dout
    m_pat[2] = 8'h77;
    m_dwl[2] = 16'd2;
    ctrl_start(1'b0);
    play("tblwr", 0, 1);
    write_reg(5'd10, {16'd2, 8'h00, 8'h77});
    play("tblwr", 1, seq_pat.size() + 2);
    m_done = 1'b1;

    // Asynchronous reset during entry 1
    ctrl_start(1'b0);
    play("arst", 0, 4);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_dout", 32'(dout), 32'd0);
    chk("arst_stat", rd_data, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    check_idle("arst_post", 3);

    // Randomized tables, lengths, loop mode and idle values
    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < 8; i++) set_entry(i, 8'($urandom_range(0, 255)), 16'($urandom_range(0, 4)));
      set_len(5'($urandom_range(0, 12)));
      set_idle(8'($urandom));
      lp = 1'($urandom_range(0, 1));
      ctrl_start(lp);
      if (m_len == 5'd0) begin
        check_idle("rnd_len0", 2);
      end else if (lp) begin
        l = seq_pat.size();
        play("rnd_loop", 0, 2 * l + 3);
        ctrl_write(32'h4);
        check_idle("rnd_stop", 1);
      end else begin
        play("rnd_one", 0, seq_pat.size() + 2);
        m_done = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
